cpu_sequencer: RTL

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_seq_pkg.sv | 15 +
 rtl/cpu_sequencer_stall_counter.sv | 34 +++
 rtl/cpu_sequencer.sv | 102 ++++++++++
 3 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the CPU sequencer: the 3-bit state enum and
// the stall counter width used when CPU_STALL_CNT_EN is defined.
package cpu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } seq_state_e;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/cpu_sequencer_stall_counter.sv
// Saturating stall-cycle counter (module seq_stall_counter); only present in
// builds that define CPU_STALL_CNT_EN.
`ifdef CPU_STALL_CNT_EN
module seq_stall_counter
  import cpu_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   inc_i,
  output logic [STALL_CNT_W-1:0] cnt_o
);

  logic [STALL_CNT_W-1:0] cnt_q;
  logic [STALL_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {STALL_CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control sequencer: IDLE -> FETCH -> EXEC [-> MEM] -> FETCH/HALT.
// Optional macro CPU_STALL_CNT_EN adds the stall_cnt output and its counter.
module cpu_sequencer
  import cpu_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   waitrequest,
  input  logic                   data_read,
  input  logic                   data_write,
  input  logic                   write_enable,
  input  logic                   halt_req,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   addr_sel,
  output logic                   ir_wren,
  output logic                   pc_wren,
  output logic                   reg_wren,
  output logic                   active,
`ifdef CPU_STALL_CNT_EN
  output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
  output logic [2:0]             state
);

  seq_state_e state_q;
  seq_state_e state_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = ST_IDLE;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr_sel  = 1'b0;
    ir_wren   = 1'b0;
    pc_wren   = 1'b0;
    reg_wren  = 1'b0;
    active    = 1'b1;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_read = 1'b1;
        if (waitrequest) begin
          state_d = ST_FETCH;
        end else begin
          ir_wren = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (data_read || data_write) begin
          state_d = ST_MEM;
        end else begin
          pc_wren  = 1'b1;
          reg_wren = write_enable;
          state_d  = halt_req ? ST_HALT : ST_FETCH;
        end
      end
      ST_MEM: begin
        addr_sel = 1'b1;
        // A load takes priority so the two bus strobes can never collide.
        mem_read  = data_read;
        mem_write = data_write && !data_read;
        if (waitrequest) begin
          state_d = ST_MEM;
        end else begin
          pc_wren  = 1'b1;
          reg_wren = write_enable;
          state_d  = halt_req ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        active  = 1'b0;
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign state = state_q;

`ifdef CPU_STALL_CNT_EN
  logic stall_inc;

  assign stall_inc = waitrequest && ((state_q == ST_FETCH) || (state_q == ST_MEM));

  seq_stall_counter u_stall_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_i   (stall_inc),
    .cnt_o   (stall_cnt)
  );
`endif

endmodule
